pipearch_multi_kernel_ctrl: RTL

Control sequencer between the AXI4-Lite control slave and NUM_INSTANCES PipeArch kernel instances, generalising the single-instance ap_start/config_regs broadcast.
- Snapshots the host-written config words on an ap_start rising edge.
- Launches the selected instances one per cycle (staggered, limiting DMA request bursts).
- Aggregates their completion into a single ap_done/ap_ready pulse.
- Reports the run length in cycles.

---
 rtl/pipearch_multi_kernel_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipearch_multi_kernel_ctrl.sv
// Launch/completion sequencer for NUM_INSTANCES PipeArch kernels behind one ap_start/ap_done handshake.
// Optional RUN-state watchdog enabled by defining PIPEARCH_CTRL_WATCHDOG_EN.
module pipearch_multi_kernel_ctrl #(
  parameter int unsigned     NUM_INSTANCES   = 4,
  parameter int unsigned     NUM_CONFIG_REGS = 4,
  parameter int unsigned     CONFIG_WIDTH    = 64,
  parameter int unsigned     CYCLE_CNT_WIDTH = 48,
  parameter longint unsigned TIMEOUT_CYCLES  = 64'hFFFF_FFFF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      ap_start,
  output logic                                      ap_idle,
  output logic                                      ap_done,
  output logic                                      ap_ready,
  input  logic [NUM_CONFIG_REGS*CONFIG_WIDTH-1:0]   cfg_data_in,
  input  logic [NUM_INSTANCES-1:0]                  inst_mask,
  output logic [NUM_CONFIG_REGS*CONFIG_WIDTH-1:0]   cfg_data_out,
  output logic [NUM_INSTANCES-1:0]                  cfg_en,
  input  logic [NUM_INSTANCES-1:0]                  inst_done,
  output logic [NUM_INSTANCES-1:0]                  run_active,
  output logic [CYCLE_CNT_WIDTH-1:0]                cycle_count,
  output logic                                      error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [CYCLE_CNT_WIDTH-1:0] LP_CNT_ONE = CYCLE_CNT_WIDTH'(1);

  state_t                                 r_state;
  state_t                                 w_state_nx;
  logic                                   r_start_q;
  logic [NUM_CONFIG_REGS*CONFIG_WIDTH-1:0] r_cfg;
  logic [NUM_INSTANCES-1:0]               r_mask_q;
  logic [NUM_INSTANCES-1:0]               r_pend;
  logic [NUM_INSTANCES-1:0]               r_done_q;
  logic [NUM_INSTANCES-1:0]               r_cfg_en;
  logic [NUM_INSTANCES-1:0]               r_run_active;
  logic [CYCLE_CNT_WIDTH-1:0]             r_cnt;

  logic                                   w_edge;
  logic                                   w_accept_start;
  logic                                   w_track;
  logic                                   w_count;
  logic                                   w_done_all;
  logic [NUM_INSTANCES-1:0]               w_low;
  logic [NUM_INSTANCES-1:0]               w_rest;
  logic [NUM_INSTANCES-1:0]               w_launch;
  logic [NUM_INSTANCES-1:0]               w_acc;

`ifdef PIPEARCH_CTRL_WATCHDOG_EN
  localparam logic [63:0] LP_TIMEOUT = 64'(TIMEOUT_CYCLES);
  logic [31:0] r_wd_cnt;
  logic        r_error;
  logic        w_abort;
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign w_edge         = ap_start & ~r_start_q;
  assign w_accept_start = (r_state == S_IDLE) && w_edge;
  assign w_track        = (r_state == S_LAUNCH) || (r_state == S_RUN);
  // A done in the same cycle as its own cfg_en pulse belongs to no run yet.
  assign w_acc          = w_track ? (inst_done & r_run_active & ~r_cfg_en & r_mask_q) : '0;
  assign w_done_all     = ((r_done_q | w_acc) == r_mask_q);
  assign w_rest         = r_pend & ~w_low;
  assign w_count        = (r_cfg_en != '0) || (r_state == S_RUN);

  // Lowest pending instance: scanning downward leaves the lowest set bit last.
  always_comb begin
    w_low = '0;
    for (int unsigned i = NUM_INSTANCES; i > 0; i--) begin
      if (r_pend[i-1]) begin
        w_low        = '0;
        w_low[i-1]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    ap_ready   = 1'b0;
    w_launch   = '0;
`ifdef PIPEARCH_CTRL_WATCHDOG_EN
    w_abort    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (w_edge) w_state_nx = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_launch = w_low;
        if (r_pend == '0)      w_state_nx = S_FINISH;
        else if (w_rest == '0) w_state_nx = S_RUN;
      end
      S_RUN: begin
        if (w_done_all) begin
          w_state_nx = S_FINISH;
        end
`ifdef PIPEARCH_CTRL_WATCHDOG_EN
        else if (64'(r_wd_cnt) >= LP_TIMEOUT) begin
          w_state_nx = S_FINISH;
          w_abort    = 1'b1;
        end
`endif
      end
      S_FINISH: begin
        ap_done    = 1'b1;
        ap_ready   = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q    <= 1'b0;
      r_cfg        <= '0;
      r_mask_q     <= '0;
      r_pend       <= '0;
      r_done_q     <= '0;
      r_cfg_en     <= '0;
      r_run_active <= '0;
      r_cnt        <= '0;
`ifdef PIPEARCH_CTRL_WATCHDOG_EN
      r_wd_cnt     <= '0;
      r_error      <= 1'b0;
`endif
    end else begin
      r_start_q <= ap_start;
      r_cfg_en  <= w_launch;
      if (w_accept_start) begin
        r_cfg        <= cfg_data_in;
        r_mask_q     <= inst_mask;
        r_pend       <= inst_mask;
        r_done_q     <= '0;
        r_run_active <= '0;
        r_cnt        <= '0;
`ifdef PIPEARCH_CTRL_WATCHDOG_EN
        r_wd_cnt     <= '0;
        r_error      <= 1'b0;
`endif
      end else begin
        r_pend       <= r_pend & ~w_launch;
        r_run_active <= (r_run_active | w_launch) & ~w_acc;
        r_done_q     <= r_done_q | w_acc;
        if (w_count && (r_cnt != '1)) r_cnt <= r_cnt + LP_CNT_ONE;
`ifdef PIPEARCH_CTRL_WATCHDOG_EN
        if (r_state == S_RUN) r_wd_cnt <= r_wd_cnt + 32'd1;
        if (w_abort) begin
          r_run_active <= '0;
          r_error      <= 1'b1;
        end
`endif
      end
    end
  end

  assign cfg_data_out = r_cfg;
  assign cfg_en       = r_cfg_en;
  assign run_active   = r_run_active;
  assign cycle_count  = r_cnt;

endmodule
